// File: rtl/lift_pkg.sv
// Shared definitions for the lift car model: state encoding, default
// geometry/timing parameters and the counter sizing helper.
package lift_pkg;

    localparam int unsigned DEF_NUM_FLOORS    = 8;
    localparam int unsigned DEF_TRAVEL_CYCLES = 16;
    localparam int unsigned DEF_DOOR_CYCLES   = 8;
    localparam int unsigned DEF_HOLD_MAX      = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOVE_UP,
        ST_MOVE_DOWN,
        ST_OPENING,
        ST_OPEN,
        ST_CLOSING,
        ST_FAULT
    } lift_state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lift_stroke_timer.sv
// Loadable down-counter that saturates at zero; done_o is high while the
// count is zero.
module lift_stroke_timer #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    output logic             done_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= value_i;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/lift_car_model.sv
// Behavioural lift car: moves between landings, strokes the door and raises
// a sticky fault on illegal command combinations. All outputs registered.
module lift_car_model
    import lift_pkg::*;
#(
    parameter int unsigned NUM_FLOORS    = DEF_NUM_FLOORS,
    parameter int unsigned TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
    parameter int unsigned DOOR_CYCLES   = DEF_DOOR_CYCLES,
    parameter int unsigned HOLD_MAX      = DEF_HOLD_MAX
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_up,
    input  logic                          cmd_down,
    input  logic                          cmd_open,
    input  logic                          cmd_close,
    input  logic                          clr_fault,
    output logic [$clog2(NUM_FLOORS)-1:0] floor,
    output logic                          at_floor,
    output logic                          door_closed,
    output logic                          door_opened,
    output logic                          moving,
    output logic                          arrive,
    output logic                          err,
    output logic                          fault
);

    localparam int unsigned FW = $clog2(NUM_FLOORS);
    localparam int unsigned CW = $clog2(max3(TRAVEL_CYCLES, DOOR_CYCLES, HOLD_MAX) + 1);

    lift_state_e   state_q, state_d;
    logic [FW-1:0] floor_q, floor_d;
    logic          at_floor_q, door_closed_q, door_opened_q, moving_q;
    logic          arrive_q, arrive_d, err_q, err_d, fault_q;
    logic          travel_load, door_load, hold_load;
    logic          travel_done, door_done, hold_done;
    logic          is_top, is_bottom, bad_dir;

    lift_stroke_timer #(.WIDTH(CW)) u_travel (
        .clk(clk), .rst(rst), .load_i(travel_load),
        .value_i(CW'(TRAVEL_CYCLES - 1)), .done_o(travel_done)
    );

    lift_stroke_timer #(.WIDTH(CW)) u_door (
        .clk(clk), .rst(rst), .load_i(door_load),
        .value_i(CW'(DOOR_CYCLES - 1)), .done_o(door_done)
    );

    lift_stroke_timer #(.WIDTH(CW)) u_hold (
        .clk(clk), .rst(rst), .load_i(hold_load),
        .value_i(CW'(HOLD_MAX - 1)), .done_o(hold_done)
    );

    assign is_top    = (floor_q == FW'(NUM_FLOORS - 1));
    assign is_bottom = (floor_q == '0);
    assign bad_dir   = cmd_up | cmd_down;

    always_comb begin
        state_d     = state_q;
        floor_d     = floor_q;
        arrive_d    = 1'b0;
        err_d       = 1'b0;
        travel_load = 1'b0;
        door_load   = 1'b0;
        hold_load   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_up && cmd_down) begin
                    state_d = ST_FAULT;
                end else if (cmd_up && !is_top) begin
                    state_d     = ST_MOVE_UP;
                    travel_load = 1'b1;
                end else if (cmd_down && !is_bottom) begin
                    state_d     = ST_MOVE_DOWN;
                    travel_load = 1'b1;
                end else if (bad_dir) begin
                    err_d = 1'b1;
                end else if (cmd_open) begin
                    state_d   = ST_OPENING;
                    door_load = 1'b1;
                end
            end
            ST_MOVE_UP, ST_MOVE_DOWN: begin
                if (travel_done) begin
                    floor_d  = (state_q == ST_MOVE_UP) ? floor_q + FW'(1) : floor_q - FW'(1);
                    arrive_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_OPENING: begin
                if (bad_dir) begin
                    state_d = ST_FAULT;
                end else if (door_done) begin
                    state_d   = ST_OPEN;
                    hold_load = 1'b1;
                end
            end
            ST_OPEN: begin
                if (bad_dir) begin
                    state_d = ST_FAULT;
                end else if (cmd_close || (!cmd_open && hold_done)) begin
                    state_d   = ST_CLOSING;
                    door_load = 1'b1;
                end else if (cmd_open) begin
                    hold_load = 1'b1;
                end
            end
            ST_CLOSING: begin
                if (bad_dir) begin
                    state_d = ST_FAULT;
                end else if (cmd_open) begin
                    state_d   = ST_OPENING;
                    door_load = 1'b1;
                end else if (door_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FAULT: begin
                // The frozen door_closed level records whether the door was shut on entry.
                if (clr_fault) begin
                    if (door_closed_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_CLOSING;
                        door_load = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            floor_q       <= '0;
            at_floor_q    <= 1'b1;
            door_closed_q <= 1'b1;
            door_opened_q <= 1'b0;
            moving_q      <= 1'b0;
            arrive_q      <= 1'b0;
            err_q         <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            arrive_q <= arrive_d;
            err_q    <= err_d;
            fault_q  <= (state_d == ST_FAULT);
            if (state_d != ST_FAULT) begin
                moving_q      <= (state_d == ST_MOVE_UP) || (state_d == ST_MOVE_DOWN);
                at_floor_q    <= !((state_d == ST_MOVE_UP) || (state_d == ST_MOVE_DOWN));
                door_closed_q <= (state_d == ST_IDLE) || (state_d == ST_MOVE_UP) ||
                                 (state_d == ST_MOVE_DOWN);
                door_opened_q <= (state_d == ST_OPEN);
            end
        end
    end

    assign floor       = floor_q;
    assign at_floor    = at_floor_q;
    assign door_closed = door_closed_q;
    assign door_opened = door_opened_q;
    assign moving      = moving_q;
    assign arrive      = arrive_q;
    assign err         = err_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_lift_car_model.sv
// Directed test of lift_car_model at default parameters: travel, range errors,
// door strokes with auto-close and reopen, faults and asynchronous reset.
module tb_lift_car_model;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_up, cmd_down, cmd_open, cmd_close, clr_fault;
    logic [2:0] floor;
    logic       at_floor, door_closed, door_opened, moving, arrive, err, fault;

    int tests    = 0;
    int failures = 0;

    lift_car_model #(
        .NUM_FLOORS(8), .TRAVEL_CYCLES(16), .DOOR_CYCLES(8), .HOLD_MAX(64)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_up(cmd_up), .cmd_down(cmd_down), .cmd_open(cmd_open),
        .cmd_close(cmd_close), .clr_fault(clr_fault),
        .floor(floor), .at_floor(at_floor), .door_closed(door_closed),
        .door_opened(door_opened), .moving(moving), .arrive(arrive),
        .err(err), .fault(fault)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // fl, at_floor, door_closed, door_opened, moving, arrive, err, fault
    task automatic chk_all(input string tag, input int fl, input logic af, input logic dc,
                           input logic dop, input logic mv, input logic ar, input logic er,
                           input logic ft);
        chk({tag, ".floor"}, 32'(floor), 32'(fl));
        chk({tag, ".at_floor"}, 32'(at_floor), 32'(af));
        chk({tag, ".door_closed"}, 32'(door_closed), 32'(dc));
        chk({tag, ".door_opened"}, 32'(door_opened), 32'(dop));
        chk({tag, ".moving"}, 32'(moving), 32'(mv));
        chk({tag, ".arrive"}, 32'(arrive), 32'(ar));
        chk({tag, ".err"}, 32'(err), 32'(er));
        chk({tag, ".fault"}, 32'(fault), 32'(ft));
    endtask

    task automatic trip_up(input int from);
        cmd_up = 1'b1;
        tick();
        cmd_up = 1'b0;
        repeat (16) tick();
        chk_all("trip_up", from + 1, 1, 1, 0, 0, 1, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        cmd_up = 0; cmd_down = 0; cmd_open = 0; cmd_close = 0; clr_fault = 0;
        #3;
        chk_all("reset", 0, 1, 1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // One-floor trip: moving for 16 cycles, then arrive pulse at floor 1
        cmd_up = 1'b1;
        tick();
        cmd_up = 1'b0;
        chk_all("move_start", 0, 0, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("move_hold.moving", 32'(moving), 32'd1);
            chk("move_hold.arrive", 32'(arrive), 32'd0);
        end
        tick();
        chk_all("arrive1", 1, 1, 1, 0, 0, 1, 0, 0);
        tick();
        chk("arrive_pulse_end", 32'(arrive), 32'd0);

        // Up to floor 3, then asynchronous reset mid-trip
        trip_up(1);
        trip_up(2);
        cmd_up = 1'b1;
        tick();
        cmd_up = 1'b0;
        repeat (5) tick();
        chk_all("mid_move_f3", 3, 0, 1, 0, 1, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 1, 1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Down at the bottom landing
        cmd_down = 1'b1;
        tick();
        cmd_down = 1'b0;
        chk_all("err_bottom", 0, 1, 1, 0, 0, 0, 1, 0);
        tick();
        chk("err_bottom_end", 32'(err), 32'd0);

        // Climb to the top, then up at the top landing
        for (int f = 0; f < 7; f++) trip_up(f);
        tick();
        cmd_up = 1'b1;
        tick();
        cmd_up = 1'b0;
        chk_all("err_top", 7, 1, 1, 0, 0, 0, 1, 0);
        tick();
        chk("err_top_end", 32'(err), 32'd0);

        // One floor down
        cmd_down = 1'b1;
        tick();
        cmd_down = 1'b0;
        chk_all("down_start", 7, 0, 1, 0, 1, 0, 0, 0);
        repeat (16) tick();
        chk_all("down_arrive", 6, 1, 1, 0, 0, 1, 0, 0);
        tick();

        // Open, auto-close after 64 hold cycles
        cmd_open = 1'b1;
        tick();
        cmd_open = 1'b0;
        chk_all("opening", 6, 1, 0, 0, 0, 0, 0, 0);
        repeat (7) tick();
        chk("opening_last", 32'(door_opened), 32'd0);
        tick();
        chk_all("open", 6, 1, 0, 1, 0, 0, 0, 0);
        repeat (63) tick();
        chk("hold_last", 32'(door_opened), 32'd1);
        tick();
        chk_all("auto_closing", 6, 1, 0, 0, 0, 0, 0, 0);
        repeat (7) tick();
        chk("closing_last", 32'(door_closed), 32'd0);
        tick();
        chk_all("closed", 6, 1, 1, 0, 0, 0, 0, 0);

        // Open, close on command, reopen at closing cycle 4
        cmd_open = 1'b1;
        tick();
        cmd_open = 1'b0;
        repeat (8) tick();
        chk("open2", 32'(door_opened), 32'd1);
        cmd_close = 1'b1;
        tick();
        cmd_close = 1'b0;
        chk_all("cmd_closing", 6, 1, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        cmd_open = 1'b1;
        tick();
        cmd_open = 1'b0;
        chk_all("reopening", 6, 1, 0, 0, 0, 0, 0, 0);
        repeat (7) tick();
        chk("reopen_last", 32'(door_opened), 32'd0);
        tick();
        chk("reopened", 32'(door_opened), 32'd1);

        // Hold restart: cmd_open after 40 cycles gives a fresh 64-cycle hold
        repeat (40) tick();
        cmd_open = 1'b1;
        tick();
        cmd_open = 1'b0;
        repeat (63) tick();
        chk("hold_restart_last", 32'(door_opened), 32'd1);
        tick();
        chk_all("restart_closing", 6, 1, 0, 0, 0, 0, 0, 0);

        // Direction command with door not closed -> fault, cleared into CLOSING
        cmd_up = 1'b1;
        tick();
        cmd_up = 1'b0;
        chk_all("door_fault", 6, 1, 0, 0, 0, 0, 0, 1);
        repeat (4) tick();
        chk("door_fault_sticky", 32'(fault), 32'd1);
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        chk_all("clr_to_closing", 6, 1, 0, 0, 0, 0, 0, 0);
        repeat (7) tick();
        chk("clr_closing_last", 32'(door_closed), 32'd0);
        tick();
        chk("clr_closed", 32'(door_closed), 32'd1);

        // Both directions in IDLE -> fault, cleared straight to IDLE
        cmd_up = 1'b1;
        cmd_down = 1'b1;
        tick();
        cmd_up = 1'b0;
        cmd_down = 1'b0;
        chk_all("both_fault", 6, 1, 1, 0, 0, 0, 0, 1);
        cmd_open = 1'b1;
        repeat (5) tick();
        cmd_open = 1'b0;
        chk_all("fault_frozen", 6, 1, 1, 0, 0, 0, 0, 1);
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        chk_all("clr_to_idle", 6, 1, 1, 0, 0, 0, 0, 0);
        cmd_up = 1'b1;
        tick();
        cmd_up = 1'b0;
        chk_all("idle_after_clr", 6, 0, 1, 0, 1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
